qspi_fifo_wr_arb: RTL



---
 rtl/qspi_fifo_arb_pkg.sv | 16 +
 rtl/qspi_rr_pick.sv | 45 ++++
 rtl/qspi_fifo_wr_arb.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/qspi_fifo_arb_pkg.sv
// Shared definitions for the QSPI TX FIFO write-side arbiter.
// Optional feature macro: QSPI_FIFO_ARB_WDOG_EN (requester-stall watchdog).
package qspi_fifo_arb_pkg;

  // Default number of requesters (command, address, data, spare).
  localparam int ARB_N_REQ_DEF    = 4;
  // Default requester-stall timeout in cycles.
  localparam int ARB_WDOG_CYC_DEF = 255;

  // Arbiter states: IDLE arbitrates, BURST streams one requester's words.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/qspi_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the
// last winner, wrapping around, so the last winner has lowest priority.
module qspi_rr_pick
  import qspi_fifo_arb_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ_DEF,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_rr_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic [PW-1:0]    o_idx,
  output logic             o_any
);

  // One extra bit so rr_ptr + offset cannot overflow before the wrap.
  localparam logic [PW:0] NREQ_W = (PW+1)'(N_REQ);

  logic [PW:0]   w_cand_sum;
  logic [PW-1:0] w_cand_idx;
  logic          w_found;

  // Walk candidates rr_ptr+1 .. rr_ptr+N_REQ (mod N_REQ); first hit wins.
  always_comb begin
    o_pick     = '0;
    o_idx      = '0;
    o_any      = |i_req;
    w_found    = 1'b0;
    w_cand_sum = '0;
    w_cand_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand_sum = {1'b0, i_rr_ptr} + (PW+1)'(k);
      if (w_cand_sum >= NREQ_W) begin
        w_cand_sum = w_cand_sum - NREQ_W;
      end
      w_cand_idx = w_cand_sum[PW-1:0];
      if (!w_found && i_req[w_cand_idx]) begin
        w_found            = 1'b1;
        o_idx              = w_cand_idx;
        o_pick[w_cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qspi_fifo_wr_arb.sv
// QSPI TX FIFO write-side arbiter: round-robin grant of the single FIFO
// write port to one requester for a whole burst of req_len+1 words,
// honouring FIFO full back-pressure. Lives in the FIFO write clock domain.
// Optional feature macro: QSPI_FIFO_ARB_WDOG_EN -- aborts a burst whose
// requester stops supplying data for WDOG_CYC cycles.
module qspi_fifo_wr_arb
  import qspi_fifo_arb_pkg::*;
#(
  parameter int N_REQ      = ARB_N_REQ_DEF,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int WDOG_CYC   = ARB_WDOG_CYC_DEF
) (
  input  logic                        w_clk,
  input  logic                        w_rst_n,
  input  logic [N_REQ-1:0]            req_vld,
  input  logic [N_REQ*LEN_WIDTH-1:0]  req_len,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_dvld,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            gnt,
  output logic                        busy,
  output logic                        burst_done,
  output logic                        burst_abort,
  output logic                        fifo_w_en,
  output logic [DATA_WIDTH-1:0]       fifo_wdata,
  input  logic                        fifo_full
);

  localparam int PW = $clog2(N_REQ);

  arb_state_t           r_state;
  logic [N_REQ-1:0]     r_gnt;
  logic [PW-1:0]        r_rr_ptr;     // last winner; also the granted index in BURST
  logic [LEN_WIDTH-1:0] r_remain;     // words still to go after the current one
  logic                 r_burst_done;

  logic [DATA_WIDTH-1:0] w_data_arr [N_REQ];
  logic [LEN_WIDTH-1:0]  w_len_arr  [N_REQ];
  logic [N_REQ-1:0]      w_pick;
  logic [PW-1:0]         w_pick_idx;
  logic                  w_any;
  logic                  w_busy;
  logic                  w_dvld_g;
  logic                  w_xfer;
  logic                  w_wdog_hit;

  // Unpack the flat per-requester buses and decode per-requester ready.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_len_arr[gi]  = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
      assign req_ready[gi]  = w_xfer && (r_rr_ptr == PW'(gi));
    end
  endgenerate

  qspi_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .i_req    (req_vld),
    .i_rr_ptr (r_rr_ptr),
    .o_pick   (w_pick),
    .o_idx    (w_pick_idx),
    .o_any    (w_any)
  );

  // A word moves only when the granted requester offers one and the FIFO has room.
  assign w_busy     = (r_state == ST_BURST);
  assign w_dvld_g   = req_dvld[r_rr_ptr];
  assign w_xfer     = w_busy && w_dvld_g && !fifo_full;
  assign fifo_w_en  = w_xfer;
  assign fifo_wdata = w_busy ? w_data_arr[r_rr_ptr] : '0;
  assign busy       = w_busy;
  assign gnt        = r_gnt;
  assign burst_done = r_burst_done;

`ifdef QSPI_FIFO_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);

  logic [WW-1:0] r_wdog_cnt;
  logic          r_burst_abort;

  // Only requester starvation counts; FIFO-full cycles leave the count alone.
  assign w_wdog_hit = w_busy && !w_dvld_g && !fifo_full &&
                      (r_wdog_cnt == WW'(WDOG_CYC - 1));

  // Count consecutive requester-stall cycles within a burst.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wdog_cnt    <= '0;
      r_burst_abort <= 1'b0;
    end else begin
      r_burst_abort <= w_wdog_hit;
      if (!w_busy || w_xfer || w_wdog_hit) begin
        r_wdog_cnt <= '0;
      end else if (!w_dvld_g && !fifo_full) begin
        r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
    end
  end

  assign burst_abort = r_burst_abort;
`else
  assign w_wdog_hit  = 1'b0;
  assign burst_abort = 1'b0;
`endif

  // Arbitration and burst FSM: grant in IDLE, count words down in BURST.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_rr_ptr     <= PW'(N_REQ - 1);
      r_remain     <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state  <= ST_BURST;
            r_gnt    <= w_pick;
            r_rr_ptr <= w_pick_idx;
            r_remain <= w_len_arr[w_pick_idx];
          end
        end
        ST_BURST: begin
          if (w_xfer) begin
            if (r_remain == '0) begin
              r_state      <= ST_IDLE;
              r_gnt        <= '0;
              r_burst_done <= 1'b1;
            end else begin
              r_remain <= r_remain - 1'b1;
            end
          end else if (w_wdog_hit) begin
            // rr_ptr keeps the aborted index so the next pick skips past it.
            r_state <= ST_IDLE;
            r_gnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

endmodule
